// File: rtl/dadda_mac_acc.sv
// dadda_mac_acc: accumulation stage behind the 8x8 Dadda multiplier.
// Each product beat is registered in stage P, then added into the
// accumulator. A burst ends with a beat marked last. The total, the beat
// count and a sticky overflow flag are then held on the result handshake
// until the consumer takes them.
// Build option: define DADDA_MAC_SAT_EN to clamp the accumulator at
// 2^ACC_W-1 on overflow. Without it the accumulator wraps.
// ACC_W must be >= PROD_W.
//
// state | meaning
// IDLE  | no burst open; acc, cnt and ovf are zero
// ACCUM | burst open; at least one non-last beat has been added
// HOLD  | result presented on out_*; input stalled until out handshake
module dadda_mac_acc #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_len,
  output logic              out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              p_valid, p_last;
  logic [PROD_W-1:0] p_data;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ovf, ovf_nxt;
  logic              load_out;
  logic              accept;
  logic [ACC_W:0]    sum;

  // Input stalls in HOLD and while the final beat still sits in P, so a
  // new burst can never start before the current result is taken. Gating
  // with rst keeps the port closed during reset.
  assign in_ready  = !rst && (state != HOLD) && !(p_valid && p_last);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);

  // One extra bit on the adder gives the carry that feeds the sticky flag.
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, p_data};

  // Stage P: register each accepted beat; empties when nothing loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_data  <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_data <= in_prod;
        p_last <= in_last;
      end
    end
  end

  // Next state, accumulator update and result capture.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    load_out  = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (p_valid) begin
`ifdef DADDA_MAC_SAT_EN
          // Once clamped, stay clamped for the rest of the burst.
          acc_nxt = (sum[ACC_W] || ovf) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_nxt = sum[ACC_W-1:0];
`endif
          ovf_nxt = ovf | sum[ACC_W];
          cnt_nxt = cnt + CNT_W'(1);
          if (p_last) begin
            state_nxt = HOLD;
            load_out  = 1'b1;
          end else begin
            state_nxt = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        acc_nxt   = '0;
        cnt_nxt   = '0;
        ovf_nxt   = 1'b0;
      end
    endcase
  end

  // State and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Result registers: capture the final totals when the burst closes and
  // keep them until the next burst closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_acc <= '0;
      out_len <= '0;
      out_ovf <= 1'b0;
    end else if (load_out) begin
      out_acc <= acc_nxt;
      out_len <= cnt_nxt;
      out_ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Bench for dadda_mac_acc: directed scenarios plus random bursts, checked
// against a burst-level arithmetic model. Follows DADDA_MAC_SAT_EN.
module tb_dadda_mac_acc;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 10;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_last;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid, out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_len;
  logic              out_ovf;

  int checks = 0;
  int errors = 0;

  dadda_mac_acc #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_len(out_len), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s timeout observed none expected event", tag);
  endtask

  // Burst-level reference: plain integer sum of the beats.
  task automatic model(input int unsigned beats[$], output logic [31:0] e_acc,
                       output logic [31:0] e_len, output logic [31:0] e_ovf);
    longint s = 0;
    foreach (beats[i]) s += longint'(beats[i]);
    e_ovf = (s > ACC_MAX) ? 1 : 0;
`ifdef DADDA_MAC_SAT_EN
    e_acc = (s > ACC_MAX) ? 32'(ACC_MAX) : 32'(s);
`else
    e_acc = 32'(s & ACC_MAX);
`endif
    e_len = 32'(beats.size() % (1 << CNT_W));
  endtask

  task automatic send_beat(input int unsigned prod, input logic last, input int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) step();
    in_prod  = PROD_W'(prod);
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin step(); n++; end
    if (n >= 50) timeout("in_ready");
    step();
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [31:0] e_acc, input logic [31:0] e_len,
                         input logic [31:0] e_ovf, input int hold);
    int n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    if (n >= 50) timeout({tag, "_out_valid"});
    check({tag, "_acc"}, 32'(out_acc), e_acc);
    check({tag, "_len"}, 32'(out_len), e_len);
    check({tag, "_ovf"}, 32'(out_ovf), e_ovf);
    check({tag, "_in_ready_hold"}, 32'(in_ready), 0);
    repeat (hold) begin
      step();
      check({tag, "_bp_valid"}, 32'(out_valid), 1);
      check({tag, "_bp_acc"}, 32'(out_acc), e_acc);
      check({tag, "_bp_len"}, 32'(out_len), e_len);
      check({tag, "_bp_in_ready"}, 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_drop"}, 32'(out_valid), 0);
    check({tag, "_ready_after"}, 32'(in_ready), 1);
    check({tag, "_acc_kept"}, 32'(out_acc), e_acc);
  endtask

  task automatic run_burst(input string tag, input int unsigned beats[$], input int max_gap,
                           input int hold);
    logic [31:0] ea, el, eo;
    foreach (beats[i])
      send_beat(beats[i], (i == beats.size() - 1), $urandom_range(max_gap, 0));
    model(beats, ea, el, eo);
    collect(tag, ea, el, eo, hold);
  endtask

  initial begin
    int unsigned q[$];
    int unsigned vals[8];
    logic [31:0] ea, el, eo;
    logic [31:0] pair_acc[4];
    int idx, res_idx, low_cnt, cyc;
    logic took;

    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_acc", 32'(out_acc), 0);
    check("rst_out_len", 32'(out_len), 0);
    check("rst_out_ovf", 32'(out_ovf), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Single beat latency: accepted in t, result valid in t+2.
    send_beat(32'hFE01, 1'b1, 0);
    check("lat_t1_in_ready", 32'(in_ready), 0);
    check("lat_t1_out_valid", 32'(out_valid), 0);
    step();
    check("lat_t2_out_valid", 32'(out_valid), 1);
    collect("single", 32'h00FE01, 1, 0, 0);

    // Bubble between the first and second beats.
    send_beat(100, 1'b0, 0);
    send_beat(200, 1'b0, 1);
    send_beat(300, 1'b1, 0);
    collect("bubble", 600, 3, 0, 0);

    // Result backpressure, then a fresh single beat.
    q = {32'd11, 32'd22, 32'd33};
    run_burst("backpr", q, 0, 5);
    q = {32'd7};
    run_burst("after_bp", q, 0, 0);

    // Overflow burst: 259 beats of 0xFE01.
    q = {};
    repeat (259) q.push_back(32'hFE01);
    model(q, ea, el, eo);
`ifdef DADDA_MAC_SAT_EN
    check("ovf_model", ea, 32'hFFFFFF);
`else
    check("ovf_model", ea, 32'h00FB03);
`endif
    run_burst("ovf", q, 0, 0);

    // Reset mid-burst discards the partial sum.
    send_beat(10, 1'b0, 0);
    send_beat(20, 1'b0, 0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    step();
    rst = 1'b0;
    #1;
    check("midrst_after_valid", 32'(out_valid), 0);
    check("midrst_after_acc", 32'(out_acc), 0);
    check("midrst_after_ready", 32'(in_ready), 1);
    q = {32'd5};
    run_burst("midrst", q, 0, 0);

    // Random bursts including zero products.
    for (int b = 0; b < 12; b++) begin
      int len = $urandom_range(8, 1);
      q = {};
      for (int k = 0; k < len; k++)
        q.push_back(($urandom_range(3, 0) == 0) ? 0 : $urandom_range(255, 0) * $urandom_range(255, 0));
      run_burst("rand", q, 2, $urandom_range(3, 0));
    end

    // Streaming: in_valid held, last on every 2nd beat, out_ready held.
    for (int i = 0; i < 8; i++) vals[i] = $urandom_range(255, 0) * $urandom_range(255, 0);
    for (int p = 0; p < 4; p++) begin
      q = {vals[2*p], vals[2*p+1]};
      model(q, ea, el, eo);
      pair_acc[p] = ea;
    end
    out_ready = 1'b1;
    idx = 0; res_idx = 0; low_cnt = 0; cyc = 0;
    in_prod = PROD_W'(vals[0]); in_last = 1'b0; in_valid = 1'b1;
    while (idx < 8 && cyc < 100) begin
      if (out_valid) begin
        if (res_idx < 4) begin
          check("stream_acc", 32'(out_acc), pair_acc[res_idx]);
          check("stream_len", 32'(out_len), 2);
          check("stream_ovf", 32'(out_ovf), 0);
        end else timeout("stream_extra_result");
        res_idx++;
      end
      if (!in_ready) low_cnt++;
      took = in_ready;
      step();
      cyc++;
      if (took) begin
        idx++;
        if (idx < 8) begin
          in_prod = PROD_W'(vals[idx]);
          in_last = (idx % 2 == 1);
        end
      end
    end
    if (idx < 8) timeout("stream_beats");
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        if (res_idx < 4) begin
          check("stream_acc", 32'(out_acc), pair_acc[res_idx]);
          check("stream_len", 32'(out_len), 2);
        end else timeout("stream_extra_result");
        res_idx++;
      end
      step();
    end
    out_ready = 1'b0;
    check("stream_results", res_idx, 4);
    check("stream_in_ready_low", low_cnt, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dadda_mac_acc.md
Name: dadda_mac_acc

Overview:
- Sequential accumulation stage directly downstream of the 8x8 Dadda multiplier.
- Consumes the 16-bit unsigned product stream through a valid/ready handshake and registers each beat to cut the compressor-tree timing path.
- Sums each burst of beats terminated by a last flag, then presents the total with beat count and overflow flag through a second valid/ready handshake.
- Builds dot products and FIR taps on top of the multiplier.

Parameters:
PROD_W, 16, product width; matches the multiplier output (2*BIT).
ACC_W, 24, accumulator/result width; must be >= PROD_W.
CNT_W, 10, beat-counter width.

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  product beat valid
in_ready  output  1  block can accept a beat this cycle
in_prod  input  PROD_W  unsigned product from multiplier `out`
in_last  input  1  beat is final term of current sum
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_acc  output  ACC_W  accumulated sum
out_len  output  CNT_W  number of beats in the sum, modulo 2^CNT_W
out_ovf  output  1  sticky: sum exceeded 2^ACC_W-1 during this burst

Behaviour:
- Reset is synchronous and active-high: `rst` high at a rising `clk` edge clears all state.
- Reset values:
  - state=IDLE, P stage invalid, acc=0, cnt=0, ovf=0.
  - out_valid=0, out_acc=0, out_len=0, out_ovf=0.
  - in_ready=0 while rst is high; in_ready=1 the first cycle after.
- Stage P (product register: p_valid, p_data, p_last) loads on the in_valid&&in_ready edge.
- P is invalidated on any edge where it does not load.
- in_ready = (state != HOLD) && !(p_valid && p_last). This is combinational from registers only and never depends on in_valid.
- Accumulate rule: on every edge with p_valid, acc <= acc + zero-extend(p_data) and cnt <= cnt + 1. The sum is computed in ACC_W+1 bits; the carry-out ORs into ovf.
- Overflow: default wraps modulo 2^ACC_W (see Optional Feature). cnt wraps modulo 2^CNT_W and does not flag overflow.
- State machine:
  - IDLE: acc=0, cnt=0, ovf=0. p_valid && !p_last -> ACCUM. p_valid && p_last -> HOLD.
  - ACCUM: p_valid && p_last -> HOLD. Otherwise stay.
  - HOLD: out_valid=1; out_acc/out_len/out_ovf show the final acc/cnt/ovf and stay stable until the handshake.
    - On out_valid && out_ready -> IDLE, clearing acc, cnt and ovf.
    - in_ready=0 throughout HOLD.
- Latency: a last beat accepted in cycle t gives out_valid=1 in cycle t+2. The earliest next accept is the cycle after out handshake.
- Bubbles between beats (in_valid low) are allowed in ACCUM; acc is unchanged on those edges.
- A zero product is a valid beat and increments cnt.
- out_valid must not drop without out_ready.
- Outside HOLD, out_acc/out_len/out_ovf hold their last presented values; they are 0 after reset.
- Reset mid-burst or in HOLD: all state clears per the reset rules, any beat in P is discarded, and no result is emitted for the partial burst.

Optional Feature:
- Macro DADDA_MAC_SAT_EN.
- Defined: on carry-out, acc clamps to 2^ACC_W-1 and remains clamped for the rest of the burst; ovf=1.
- Undefined: acc wraps modulo 2^ACC_W; ovf=1.
- Handshake and latency are identical in both builds.

Test Plan:
1. Single beat in_prod=0xFE01 (255*255), in_last=1, accepted cycle t -> out_valid in cycle t+2; out_acc=0x00FE01, out_len=1, out_ovf=0; in_ready=0 in cycles t+1..HOLD.
2. Beats 100, 200, 300 (last on third), with one in_valid=0 bubble between the 1st and 2nd -> out_acc=600, out_len=3, out_ovf=0.
3. Result backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_acc and out_len stable; in_ready=0. Then out_ready=1 for 1 cycle -> IDLE, and a following beat 7 (last) gives out_acc=7, out_len=1.
4. Overflow: 259 beats of 0xFE01, last on beat 259.
   - Without macro: out_acc=0x00FB03, out_ovf=1, out_len=259.
   - With DADDA_MAC_SAT_EN: out_acc=0xFFFFFF, out_ovf=1, out_len=259.
5. Reset mid-burst: beats 10 and 20 accepted, then rst=1 for one cycle -> out_valid=0, in_ready=0 during reset. Then beat 5 (last) gives out_acc=5, out_len=1, out_ovf=0.
6. Streaming: in_valid held at 1, in_last on every 2nd beat, out_ready held at 1 -> no beat lost; each result equals the pair sum; in_ready low for exactly the P-last cycle plus the HOLD cycle per burst.
